leaf_stream_fifo_stage: RTL
===========================

Name: leaf_stream_fifo_stage

Overview:
Leaf-level buffering stage instantiated beneath the generated hierarchy nodes. It gives the otherwise port-less subtree a real sequential endpoint. It accepts a valid/ready byte stream and holds it in a small first-word-fall-through FIFO. It drains the FIFO to a downstream valid/ready consumer and keeps a running XOR checksum and a transfer counter of all words delivered.

Parameters:
DATA_W, 8, width of each data word
DEPTH, 4, FIFO entries; power of two, DEPTH >= 2
CNT_W, 16, width of the delivered-word counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush: empties the FIFO
chk_clr  input  1  synchronous clear of the checksum and the counter
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept a word
in_data  input  DATA_W  upstream word
out_valid  output  1  head word available
out_ready  input  1  downstream accepts the head word
out_data  output  DATA_W  head word
level  output  $clog2(DEPTH+1)  current occupancy
checksum  output  DATA_W  XOR of all words delivered since the last clear
xfer_cnt  output  CNT_W  count of words delivered since the last clear

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, level = 0, checksum = 0, xfer_cnt = 0. Storage contents are don't-care. in_ready = 0 while in reset, 1 on the first cycle after reset release. out_valid = 0.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Both take effect on the rising edge.
  - Upstream must hold in_data stable while in_valid is high and in_ready is low. The stage does not check this.
- Ready and valid:
  - in_ready = rst_n & !flush & (level != DEPTH). Purely combinational from state and flush; never depends on in_valid.
  - out_valid = !flush & (level != 0).
  - out_data = mem[rd_ptr], combinational from registered storage (first-word-fall-through).
- Latency: a word pushed in cycle N appears on out_data with out_valid in cycle N+1 if the FIFO was empty. Throughput is 1 word/cycle.
- Simultaneous events:
  - push and pop in the same cycle: level unchanged; both pointers advance.
  - Full: a pop in the full cycle frees a slot, but in_ready stays low that cycle. No push-through when full.
  - Empty: out_valid is low. A push into an empty FIFO is not forwarded in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level tracks occupancy separately, so full and empty are unambiguous.
- flush: next edge wr_ptr = rd_ptr = 0, level = 0. No push or pop happens in a flush cycle (ready and valid are both forced low). checksum and xfer_cnt are unaffected by flush.
- Checksum and counter:
  - On each pop: checksum <= checksum ^ out_data; xfer_cnt <= xfer_cnt + 1, wrapping modulo 2^CNT_W.
  - chk_clr has priority: if chk_clr and a pop coincide, checksum = 0 and xfer_cnt = 0. The popped word is not accumulated, but it still leaves the FIFO.
- Reset asserted mid-transfer: all state returns to reset values immediately. In-flight words are lost, and no pop or push is counted for that cycle.

Test Plan:
- Reset then idle: after reset release, out_valid = 0, in_ready = 1, level = 0, checksum = 0x00, xfer_cnt = 0.
- Fill to full with out_ready = 0: push 0x11, 0x22, 0x33, 0x44 -> level = 4, in_ready = 0. A fifth in_valid with 0x55 is not accepted. out_data = 0x11.
- Drain with out_ready = 1: pops in order 0x11, 0x22, 0x33, 0x44, one per cycle -> checksum = 0x44 (0x11^0x22^0x33^0x44), xfer_cnt = 4, level = 0, out_valid = 0.
- Streaming wrap: in_valid and out_ready held high for 10 words 0x01..0x0A -> each output appears 1 cycle after its input, level stays 1, pointers wrap twice, xfer_cnt = 10, checksum = 0x0B.
- Flush plus clear collision: with 3 words queued, assert flush for one cycle -> level = 0, in_ready = 0 and out_valid = 0 during the flush cycle, checksum and xfer_cnt unchanged. Separately, assert chk_clr together with a pop of 0x5A -> checksum = 0x00, xfer_cnt = 0, level decremented by 1.
- Async reset mid-stream: assert rst_n low between clock edges with level = 2 -> level, checksum and xfer_cnt read 0 before the next edge; out_valid = 0.

Source files
------------

// File: rtl/leaf_stream_fifo_stage.sv
// Leaf buffering stage: small first-word-fall-through FIFO between two valid/ready
// byte streams, with a running XOR checksum and count of delivered words.
module leaf_stream_fifo_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         chk_clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [DATA_W-1:0]            checksum,
    output logic [CNT_W-1:0]             xfer_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Handshake qualifiers; flush forces both sides idle for the cycle.
    assign in_ready  = rst_n & ~flush & (level != LVL_W'(DEPTH));
    assign out_valid = ~flush & (level != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage needs no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally; level disambiguates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Delivery statistics; a clear wins over a coincident pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
            xfer_cnt <= '0;
        end else if (chk_clr) begin
            checksum <= '0;
            xfer_cnt <= '0;
        end else if (pop) begin
            checksum <= checksum ^ out_data;
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule
